// File: rtl/floppy_pkg.sv
// Shared register map, channel bit positions and widths for the floppy register bank.
package floppy_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 8;
  localparam int NOTE_W  = 7;
  localparam int SP_W    = 23;
  localparam int MAX_CH  = 8;

  localparam logic [ADDR_W-1:0] ADDR_CH_BASE = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 6'h21;
  localparam logic [ADDR_W-1:0] ADDR_TIMEOUT = 6'h22;

  localparam int CH_EN_BIT        = 7;
  localparam int CH_NOTE_MSB      = 6;
  localparam int CTRL_ALL_OFF_BIT = 0;

endpackage

// File: rtl/floppy_lookup.sv
// MIDI note to step-period setpoint: per-semitone period of octave -1 at 50 MHz,
// halved once per octave above it.
module floppy_lookup
  import floppy_pkg::*;
(
  input  logic [NOTE_W-1:0] note,
  output logic [SP_W-1:0]   setpoint
);

  logic [NOTE_W-1:0] octave;
  logic [NOTE_W-1:0] semitone;
  logic [SP_W-1:0]   base;

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    base     = 23'd3239623;
    octave   = note / 7'd12;
    semitone = note - octave * 7'd12;
    case (semitone)
      7'd0:    base = 23'd6115610;
      7'd1:    base = 23'd5772367;
      7'd2:    base = 23'd5448389;
      7'd3:    base = 23'd5142567;
      7'd4:    base = 23'd4853963;
      7'd5:    base = 23'd4581532;
      7'd6:    base = 23'd4324383;
      7'd7:    base = 23'd4081666;
      7'd8:    base = 23'd3852571;
      7'd9:    base = 23'd3636364;
      7'd10:   base = 23'd3432265;
      default: base = 23'd3239623;
    endcase
    setpoint = base >> octave;
  end

endmodule

// File: rtl/floppy_reg_bank.sv
// Floppy-drive music register bank: channel note/enable registers, CTRL, STATUS.
// Define FLOPPY_AUTO_OFF_EN to add the TIMEOUT register and 10 ms auto-off hold counters.
module floppy_reg_bank
  import floppy_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CLK_HZ = 50000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      reg_addr,
  input  logic                   write,
  input  logic                   new_req,
  input  logic [DATA_W-1:0]      write_value,
  output logic [DATA_W-1:0]      read_value,
  output logic [DATA_W-1:0]      led,
  output logic [NUM_CH*SP_W-1:0] f_sp,
  output logic [NUM_CH-1:0]      f_en
);

  logic [DATA_W-1:0] ch_reg [NUM_CH];
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] expire;
  logic [DATA_W-1:0] rd_mux;
  logic              wr_en;
  logic              rd_req;
  logic              all_off;

  assign wr_en   = new_req && write;
  assign rd_req  = new_req && !write;
  assign all_off = wr_en && (reg_addr == ADDR_CTRL) && write_value[CTRL_ALL_OFF_BIT];
  assign led     = ch_reg[0];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign ch_wr[n] = wr_en && (reg_addr == ADDR_CH_BASE + ADDR_W'(n));
    assign f_en[n]  = ch_reg[n][CH_EN_BIT];

    floppy_lookup u_lookup (
      .note     (ch_reg[n][CH_NOTE_MSB:0]),
      .setpoint (f_sp[n*SP_W +: SP_W])
    );
  end

`ifdef FLOPPY_AUTO_OFF_EN
  localparam int unsigned TICK_DIV = (CLK_HZ >= 200) ? CLK_HZ / 100 : 2;
  localparam int          PRE_W    = $clog2(TICK_DIV);

  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic [DATA_W-1:0] timeout;
  logic [DATA_W-1:0] hold [NUM_CH];

  assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

  for (genvar n = 0; n < NUM_CH; n++) begin : g_exp
    assign expire[n] = tick && (hold[n] == 8'd1) && ch_reg[n][CH_EN_BIT] && (timeout != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      timeout <= '0;
      for (int n = 0; n < NUM_CH; n++) hold[n] <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (wr_en && (reg_addr == ADDR_TIMEOUT)) timeout <= write_value;
      for (int n = 0; n < NUM_CH; n++) begin
        // A channel write blocks this cycle's decrement; only a note-on reloads.
        if (ch_wr[n]) begin
          if (write_value[CH_EN_BIT]) hold[n] <= timeout;
        end else if (all_off) begin
          hold[n] <= '0;
        end else if (tick && (hold[n] != '0) && ch_reg[n][CH_EN_BIT]) begin
          hold[n] <= hold[n] - 1'b1;
        end
      end
    end
  end
`else
  assign expire = '0;
`endif

  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (reg_addr == ADDR_CH_BASE + ADDR_W'(n)) rd_mux = ch_reg[n];
    end
    if (reg_addr == ADDR_STATUS) rd_mux[NUM_CH-1:0] = f_en;
`ifdef FLOPPY_AUTO_OFF_EN
    if (reg_addr == ADDR_TIMEOUT) rd_mux = timeout;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_value <= '0;
      // NOTE: the register file is small and its reset state is architectural, so it is cleared explicitly.
      for (int n = 0; n < NUM_CH; n++) ch_reg[n] <= '0;
    end else begin
      if (rd_req) read_value <= rd_mux;
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_wr[n])                  ch_reg[n]            <= write_value;
        else if (all_off || expire[n]) ch_reg[n][CH_EN_BIT] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_floppy_reg_bank.sv
// Scoreboard bench for floppy_reg_bank; auto-off scenarios run when FLOPPY_AUTO_OFF_EN is defined.
module tb_floppy_reg_bank;
  import floppy_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CLK_HZ = 1000;

  localparam logic [22:0] LK0  = 23'd6115610;
  localparam logic [22:0] LK5  = 23'd4581532;
  localparam logic [22:0] LK60 = 23'd191112;
  localparam logic [22:0] LK69 = 23'd113636;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [ADDR_W-1:0]      reg_addr = '0;
  logic                   write = 1'b0;
  logic                   new_req = 1'b0;
  logic [DATA_W-1:0]      write_value = '0;
  logic [DATA_W-1:0]      read_value;
  logic [DATA_W-1:0]      led;
  logic [NUM_CH*SP_W-1:0] f_sp;
  logic [NUM_CH-1:0]      f_en;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  logic [7:0] exp_q  [$];
  string      name_q [$];
  logic       rd_pending = 1'b0;

  floppy_reg_bank #(.NUM_CH(NUM_CH), .CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_addr    (reg_addr),
    .write       (write),
    .new_req     (new_req),
    .write_value (write_value),
    .read_value  (read_value),
    .led         (led),
    .f_sp        (f_sp),
    .f_en        (f_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Monitor: a read sampled at an edge presents read_value after that edge.
  always @(posedge clk) rd_pending <= new_req && !write && !rst;

  always @(negedge clk) begin
    if (rd_pending) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(read_value), 32'hFFFF_FFFF);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        automatic string      n = name_q.pop_front();
        check(n, 32'(read_value), 32'(e));
      end
    end
  end

  // All drive tasks are entered at a negedge; the request is sampled at the next posedge.
  task automatic wr(input logic [5:0] a, input logic [7:0] v);
    reg_addr = a; write = 1'b1; write_value = v; new_req = 1'b1;
    @(negedge clk);
    new_req = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] e, input string name);
    exp_q.push_back(e);
    name_q.push_back(name);
    reg_addr = a; write = 1'b0; new_req = 1'b1;
    @(negedge clk);
    new_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(1);

    check("rst_led",   32'(led), 32'h00);
    check("rst_f_en",  32'(f_en), 32'h0);
    check("rst_rdval", 32'(read_value), 32'h00);
    check("rst_sp0",   32'(f_sp[22:0]), 32'(LK0));
    check("rst_sp3",   32'(f_sp[91:69]), 32'(LK0));

    wr(6'h00, 8'hBC);
    rd(6'h00, 8'hBC, "rd_ch0");
    check("led_bc",  32'(led), 32'hBC);
    check("en0",     32'(f_en[0]), 32'h1);
    check("sp0_n60", 32'(f_sp[22:0]), 32'(LK60));

    wr(6'h00, 8'h3C);
    wr(6'h03, 8'h85);
    rd(6'h21, 8'h08, "rd_status_ch3");
    check("sp3_n5", 32'(f_sp[91:69]), 32'(LK5));
    rd(6'h05, 8'h00, "rd_unmapped_ch5");
    wr(6'h05, 8'hFF);
    rd(6'h05, 8'h00, "rd_ch5_after_wr");
    rd(6'h03, 8'h85, "rd_ch3");
    wr(6'h21, 8'hFF);
    rd(6'h21, 8'h08, "rd_status_ro");
    rd(6'h20, 8'h00, "rd_ctrl");
    rd(6'h3F, 8'h00, "rd_unmapped_3f");

    wr(6'h00, 8'hBC);
    wr(6'h01, 8'h90);
    wr(6'h02, 8'hC5);
    wr(6'h03, 8'h85);
    check("all_en",  32'(f_en), 32'hF);
    check("sp2_n69", 32'(f_sp[68:46]), 32'(LK69));
    wr(6'h20, 8'h01);
    check("alloff_en",  32'(f_en), 32'h0);
    check("alloff_led", 32'(led), 32'h3C);
    rd(6'h02, 8'h45, "rd_ch2_alloff");
    rd(6'h03, 8'h05, "rd_ch3_alloff");
    wr(6'h20, 8'hFE);
    wr(6'h01, 8'h90);
    wr(6'h20, 8'hFE);
    check("ctrl_bit0_only", 32'(f_en), 32'h2);
    wr(6'h20, 8'h01);

`ifdef FLOPPY_AUTO_OFF_EN
    begin
      int wr_edge, fall_edge, phase, e_edge, r_edge;
      bit fell;
      wr(6'h22, 8'd3);
      rd(6'h22, 8'd3, "rd_timeout");

      wr_edge = cyc + 1;
      wr(6'h01, 8'h90);
      fell = 1'b0;
      fall_edge = 0;
      for (int i = 0; i < 50 && !fell; i++) begin
        if (f_en[1] == 1'b0) begin fell = 1'b1; fall_edge = cyc; end
        else @(negedge clk);
      end
      check("autooff_fell", 32'(fell), 32'h1);
      check("autooff_window", 32'((fall_edge - wr_edge) >= 21 && (fall_edge - wr_edge) <= 30), 32'h1);
      rd(6'h01, 8'h10, "rd_ch1_expired");

      // Tick edges are congruent to fall_edge mod 10; issue a note-on just after one.
      phase = fall_edge % 10;
      for (int i = 0; i < 10 && (cyc % 10) != phase; i++) @(negedge clk);
      e_edge = cyc + 1;
      wr(6'h01, 8'h90);
      while (cyc < e_edge + 28) @(negedge clk);
      r_edge = cyc + 1;
      wr(6'h01, 8'h90);
      check("rewrite_on_expiry_en", 32'(f_en[1]), 32'h1);
      while (cyc < r_edge + 29) @(negedge clk);
      check("reload_before_expiry", 32'(f_en[1]), 32'h1);
      idle(1);
      check("reload_expired", 32'(f_en[1]), 32'h0);

      wr(6'h01, 8'h90);
      idle(5);
      rst = 1'b1;
      reg_addr = 6'h00; write = 1'b1; write_value = 8'hFF; new_req = 1'b1;
      idle(1);
      rst = 1'b0; new_req = 1'b0; write = 1'b0;
      check("midrst_led",   32'(led), 32'h00);
      check("midrst_f_en",  32'(f_en), 32'h0);
      check("midrst_rdval", 32'(read_value), 32'h00);
      check("midrst_sp1",   32'(f_sp[45:23]), 32'(LK0));
      rd(6'h22, 8'h00, "rd_timeout_after_rst");
      wr(6'h01, 8'h90);
      idle(60);
      check("no_spurious_expiry", 32'(f_en[1]), 32'h1);
    end
`else
    wr(6'h22, 8'h07);
    rd(6'h22, 8'h00, "rd_timeout_unmapped");
    wr(6'h01, 8'h90);
    idle(60);
    check("hold_no_autooff", 32'(f_en[1]), 32'h1);
    idle(2);
    rst = 1'b1;
    reg_addr = 6'h00; write = 1'b1; write_value = 8'hFF; new_req = 1'b1;
    idle(1);
    rst = 1'b0; new_req = 1'b0; write = 1'b0;
    check("midrst_led",  32'(led), 32'h00);
    check("midrst_f_en", 32'(f_en), 32'h0);
    check("midrst_sp1",  32'(f_sp[45:23]), 32'(LK0));
`endif

    idle(3);
    check("rd_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
